to_bcd: RTL and testbench

//   Sequential binary-to-BCD converter (shift-add-3 / double-dabble) for the SPM result display path.

---
 rtl/to_bcd_if.sv | 25 ++
 rtl/to_bcd.sv | 86 ++++++++
 tb/tb_to_bcd.sv | 125 ++++++++++++
 3 files changed

// File: rtl/to_bcd_if.sv
// Conversion handshake between the magnitude source and the BCD converter.
// The master drives start/bin_d_in; the slave returns the digits and status.
interface to_bcd_if;
    logic        start;
    logic [14:0] bin_d_in;
    logic [18:0] bcd_d_out;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output bin_d_in,
        input  bcd_d_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  bin_d_in,
        output bcd_d_out,
        output busy,
        output done
    );
endinterface

// File: rtl/to_bcd.sv
// Sequential 15-bit binary to 5-digit packed BCD converter (shift-add-3).
// One conversion per 17 clocks; bcd_d_out holds the last completed result.
//
// state | meaning
// IDLE  | waiting for start, result held
// CONV  | 15 add-3/shift iterations
// FIN   | publish accumulator, pulse done
module to_bcd (
    input  logic     clk,
    input  logic     rst,
    to_bcd_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

    state_t      state;
    state_t      state_next;
    logic [14:0] bin_sr;
    logic [18:0] acc;
    logic [18:0] acc_adj;
    logic [3:0]  count;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // The 3-bit top field never reaches 5 for 15-bit inputs; adjusted anyway for symmetry.
    always_comb begin
        acc_adj[18:16] = (acc[18:16] >= 3'd5) ? acc[18:16] + 3'd3 : acc[18:16];
        acc_adj[15:12] = add3(acc[15:12]);
        acc_adj[11:8]  = add3(acc[11:8]);
        acc_adj[7:4]   = add3(acc[7:4]);
        acc_adj[3:0]   = add3(acc[3:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CONV;
            CONV:    if (count == 4'd1) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr        <= '0;
            acc           <= '0;
            count         <= '0;
            bus.bcd_d_out <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_sr   <= bus.bin_d_in;
                        acc      <= '0;
                        count    <= 4'd15;
                        bus.busy <= 1'b1;
                    end
                end
                CONV: begin
                    acc    <= {acc_adj[17:0], bin_sr[14]};
                    bin_sr <= {bin_sr[13:0], 1'b0};
                    count  <= count - 4'd1;
                end
                FIN: begin
                    bus.bcd_d_out <= acc;
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_to_bcd.sv
// Directed bench for to_bcd: hand-computed BCD results, latency, busy-ignore and abort.
module tb_to_bcd;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    int   lat;
    int   n_done;

    to_bcd_if bus ();

    to_bcd dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept on the next edge, then expect done exactly 16 edges later with exp.
    task automatic conv(input logic [14:0] b, input logic [18:0] exp, input string tag);
        bus.start    = 1'b1;
        bus.bin_d_in = b;
        tick();
        bus.start    = 1'b0;
        bus.bin_d_in = 15'h7fff;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd16);
        chk({tag, "_bcd"}, 32'(bus.bcd_d_out), 32'(exp));
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        tick();
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.bin_d_in = 15'd77;
        tick();
        tick();
        chk("rst_bcd", 32'(bus.bcd_d_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        chk("rst_hold_busy", 32'(bus.busy), 32'd0);

        conv(15'd0,     19'h0_0000, "c0");
        conv(15'd9,     19'h0_0009, "c9");
        conv(15'd45,    19'h0_0045, "c45");
        conv(15'd123,   19'h0_0123, "c123");
        conv(15'd999,   19'h0_0999, "c999");
        conv(15'd1234,  19'h0_1234, "c1234");
        conv(15'd9999,  19'h0_9999, "c9999");
        conv(15'd32767, 19'h3_2767, "c32767");

        // start held high with changing bin_d_in while busy
        bus.start    = 1'b1;
        bus.bin_d_in = 15'd500;
        tick();
        n_done = 0;
        lat    = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            bus.bin_d_in = (lat % 2 == 0) ? 15'd777 : 15'd31000;
            tick();
            lat++;
        end
        if (bus.done === 1'b1) n_done++;
        bus.start = 1'b0;
        chk("hold_lat", 32'(lat), 32'd16);
        chk("hold_bcd", 32'(bus.bcd_d_out), 32'h0_0500);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        chk("hold_once", 32'(n_done), 32'd1);
        chk("hold_keep", 32'(bus.bcd_d_out), 32'h0_0500);

        // abort a conversion of 999 at iteration 8
        bus.start    = 1'b1;
        bus.bin_d_in = 15'd999;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("abort_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_bcd", 32'(bus.bcd_d_out), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        chk("abort_nodone", 32'(n_done), 32'd0);
        conv(15'd999, 19'h0_0999, "after_abort");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
